barrett_reduce_pipe: RTL and testbench

- Multi-lane, pipelined modular reducer for the Kyber arithmetic datapath: r = c mod Q for unsigned products up to IN_W bits.
- Uses Barrett reduction with one conditional subtract, so it works for any odd Q, not only 3329.
- Adds valid/ready flow control with per-stage stalls, an optional per-lane negation (Q - r) mod Q for NTT butterfly subtraction, and a passthrough tag.
- Sits between the coefficient multipliers and the NTT/poly-arith writeback.

---
 rtl/kyber_pkg.sv | 26 ++
 rtl/barrett_lane.sv | 69 ++++++
 rtl/barrett_reduce_pipe.sv | 77 +++++++
 tb/tb_barrett_reduce_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and elaboration-time helpers.
package kyber_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_QW = 12;

  // Barrett multiplier floor(2^in_w / q).
  function automatic longint barrett_m(input longint q, input int in_w);
    longint one;
    one = 1;
    return (one << in_w) / q;
  endfunction

  function automatic int clog2_f(input longint v);
    int     n;
    longint x;
    n = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/barrett_lane.sv
// One lane of the 3-stage Barrett datapath: estimate, subtract, correct/negate.
// Stage loads are driven externally; this block has no notion of valid/ready.
module barrett_lane
  import kyber_pkg::*;
#(
  parameter int Q    = KYBER_Q,
  parameter int QW   = KYBER_QW,
  parameter int IN_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en1,
  input  logic            en2,
  input  logic            en3,
  input  logic [IN_W-1:0] c,
  input  logic            neg,
  output logic [QW-1:0]   r
);

  localparam int MW = IN_W - QW + 2;
  localparam int PW = IN_W + MW;
  localparam logic [MW-1:0] M  = MW'(barrett_m(longint'(Q), IN_W));
  localparam logic [QW:0]   QE = (QW+1)'(Q);
  localparam logic [QW-1:0] QN = QW'(Q);

  logic [IN_W-1:0] s1_c;
  logic [MW-1:0]   s1_hi;
  logic            s1_neg;
  logic [QW:0]     s2_r0;
  logic            s2_neg;

  logic [PW-1:0]   prod;
  logic [IN_W-1:0] tq;
  logic [QW-1:0]   r_red;
  logic [QW-1:0]   r_fin;

  assign prod = PW'(c) * PW'(M);
  assign tq   = IN_W'(s1_hi) * IN_W'(Q);

  // r0 < 2Q always, so QW+1 low bits of the difference are exact.
  always_comb begin
    r_red = (s2_r0 >= QE) ? QW'(s2_r0 - QE) : QW'(s2_r0);
    r_fin = r_red;
    if (s2_neg) r_fin = (r_red == '0) ? '0 : QN - r_red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_c   <= '0;
      s1_hi  <= '0;
      s1_neg <= 1'b0;
      s2_r0  <= '0;
      s2_neg <= 1'b0;
      r      <= '0;
    end else begin
      if (en1) begin
        s1_c   <= c;
        s1_hi  <= MW'(prod >> IN_W);
        s1_neg <= neg;
      end
      if (en2) begin
        s2_r0  <= (QW+1)'(s1_c - tq);
        s2_neg <= s1_neg;
      end
      if (en3) r <= r_fin;
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Multi-lane pipelined c mod Q reducer with optional negation and a sideband tag.
// Three-stage valid chain with per-stage stalls; holds up to three beats under backpressure.
module barrett_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int QW    = KYBER_QW,
  parameter int IN_W  = 24,
  parameter int LANES = 2,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic [LANES-1:0]      in_neg,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*QW-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag
);

  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic en1, en2, en3;
  logic [TAG_W-1:0] tag1, tag2;

  // A stage may load if it is empty or its contents move on this edge.
  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;

  assign en1 = ld1 && in_valid;
  assign en2 = ld2 && v1;
  assign en3 = ld3 && v2;

  assign in_ready  = ld1;
  assign out_valid = v3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      tag1    <= '0;
      tag2    <= '0;
      out_tag <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (en1) tag1 <= in_tag;
      if (en2) tag2 <= tag1;
      if (en3) out_tag <= tag2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    barrett_lane #(
      .Q    (Q),
      .QW   (QW),
      .IN_W (IN_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en1 (en1),
      .en2 (en2),
      .en3 (en3),
      .c   (in_data[i*IN_W +: IN_W]),
      .neg (in_neg[i]),
      .r   (out_data[i*QW +: QW])
    );
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed and randomized checks for barrett_reduce_pipe, plus a Q=7681 four-lane instance.
module tb_barrett_reduce_pipe;

  localparam int Q = 3329;

  typedef struct packed {
    logic [23:0] c0;
    logic [23:0] c1;
    logic        n0;
    logic        n1;
    logic [7:0]  tag;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [47:0] in_data;
  logic [1:0]  in_neg;
  logic [7:0]  in_tag;
  logic [23:0] out_data;
  logic [7:0]  out_tag;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [103:0] b_in_data;
  logic [3:0]   b_in_neg;
  logic [7:0]   b_in_tag;
  logic [51:0]  b_out_data;
  logic [7:0]   b_out_tag;

  int n_vec = 0;
  int n_err = 0;

  int          idx, ndel, stale, acc_n, del_n, nwait;
  logic        acc_now, del_now;
  logic [23:0] hold0;
  beat_t       cur, bq;
  beat_t       sbq[$];

  always #5 clk = ~clk;

  barrett_reduce_pipe #(.Q(3329), .QW(12), .IN_W(24), .LANES(2), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_neg(in_neg), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  barrett_reduce_pipe #(.Q(7681), .QW(13), .IN_W(26), .LANES(4), .TAG_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_neg(b_in_neg), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_mod(input logic [23:0] c, input logic n);
    int r;
    r = int'(c) % Q;
    if (n && r != 0) r = Q - r;
    return 12'(r);
  endfunction

  // Single beat into an empty pipe with out_ready held high.
  task automatic beat(input logic [23:0] c0, input logic [23:0] c1, input logic n0, input logic n1,
                      input logic [7:0] tg, input logic [11:0] e0, input logic [11:0] e1);
    in_data  = {c1, c0};
    in_neg   = {n1, n0};
    in_tag   = tg;
    in_valid = 1'b1;
    @(negedge clk);
    check("acc_rdy", 64'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 check("lat_early", 64'(out_valid), 0);
    @(posedge clk); #1 check("lat_valid", 64'(out_valid), 1);
    check("lane0", 64'(out_data[11:0]), 64'(e0));
    check("lane1", 64'(out_data[23:12]), 64'(e1));
    check("tag", 64'(out_tag), 64'(tg));
    @(posedge clk); #1 check("drained", 64'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_neg = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_neg = '0; b_in_tag = '0; b_out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_tag", 64'(out_tag), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    beat(24'd0, 24'd3329, 1'b0, 1'b0, 8'h01, 12'd0, 12'd0);
    beat(24'd11075584, 24'd16777215, 1'b0, 1'b0, 8'h02, 12'd1, 12'd2384);
    beat(24'd1, 24'd3329, 1'b1, 1'b1, 8'h03, 12'd3328, 12'd0);
    beat(24'd3330, 24'd3330, 1'b1, 1'b0, 8'h04, 12'd3328, 12'd1);
    beat(24'd5, 24'd5, 1'b0, 1'b1, 8'h05, 12'd5, 12'd3324);

    // Backpressure: beat k carries lane0 -> k+10, lane1 -> k+20, tag 0x40+k.
    out_ready = 1'b0;
    idx = 0;
    in_neg = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (idx < 5);
      in_data  = {24'(6678 + idx), 24'(3330 * idx + 10)};
      in_tag   = 8'(64 + idx);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (cyc == 7) hold0 = out_data;
      @(posedge clk); #1;
      if (acc_now) idx++;
    end
    check("bp_accepted", 64'(idx), 3);
    check("bp_in_ready", 64'(in_ready), 0);
    check("bp_out_valid", 64'(out_valid), 1);
    check("bp_head", 64'(out_data), 64'({12'd20, 12'd10}));
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold", 64'(out_data), 64'(hold0));
    check("bp_hold_tag", 64'(out_tag), 64'h40);

    out_ready = 1'b1;
    ndel = 0;
    for (int cyc = 0; cyc < 40 && ndel < 5; cyc++) begin
      in_valid = (idx < 5);
      in_data  = {24'(6678 + idx), 24'(3330 * idx + 10)};
      in_tag   = 8'(64 + idx);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        check("bp_order", 64'({out_tag, out_data}), 64'({8'(64 + ndel), 12'(20 + ndel), 12'(10 + ndel)}));
        ndel++;
      end
      @(posedge clk); #1;
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    check("bp_delivered", 64'(ndel), 5);
    check("bp_total_acc", 64'(idx), 5);
    @(posedge clk); #1;
    check("bp_empty", 64'(out_valid), 0);

    // Reset with a full pipe.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = {24'(k + 1), 24'(k + 1)};
      in_tag   = 8'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 0);
    check("rst_async_data", 64'(out_data), 0);
    check("rst_async_tag", 64'(out_tag), 0);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst_stale", 64'(stale), 0);
    beat(24'd16777215, 24'd6661, 1'b1, 1'b0, 8'h77, 12'd945, 12'd3);

    // Q=7681 four-lane instance at its boundaries.
    b_in_data  = {26'(67108863), 26'(67108863), 26'(7681), 26'(7680)};
    b_in_neg   = 4'b1000;
    b_in_tag   = 8'h5A;
    b_in_valid = 1'b1;
    @(negedge clk);
    check("b_rdy", 64'(b_in_ready), 1);
    @(posedge clk); #1 b_in_valid = 1'b0;
    nwait = 0;
    while (!b_out_valid && nwait < 10) begin
      @(posedge clk); #1;
      nwait++;
    end
    check("b_latency", 64'(nwait), 2);
    check("b_lane0", 64'(b_out_data[12:0]), 7680);
    check("b_lane1", 64'(b_out_data[25:13]), 0);
    check("b_lane2", 64'(b_out_data[38:26]), 7647);
    check("b_lane3", 64'(b_out_data[51:39]), 34);
    check("b_tag", 64'(b_out_tag), 64'h5A);

    // Random traffic against a c mod Q scoreboard.
    sbq.delete();
    acc_n = 0;
    del_n = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && del_n < 10000; cyc++) begin
      if (!in_valid && acc_n < 10000 && $urandom_range(3) != 0) begin
        cur.c0  = ($urandom_range(7) == 0) ? 24'hFFFFFF : 24'($urandom);
        cur.c1  = ($urandom_range(7) == 0) ? 24'(Q * $urandom_range(5000)) : 24'($urandom);
        cur.n0  = 1'($urandom_range(1));
        cur.n1  = 1'($urandom_range(1));
        cur.tag = 8'($urandom);
        in_data  = {cur.c1, cur.c0};
        in_neg   = {cur.n1, cur.n0};
        in_tag   = cur.tag;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      del_now = out_valid && out_ready;
      if (del_now) begin
        if (sbq.size() == 0) begin
          check("rnd_spurious", 64'(out_valid), 0);
        end else begin
          bq = sbq.pop_front();
          check("rnd_lane0", 64'(out_data[11:0]), 64'(ref_mod(bq.c0, bq.n0)));
          check("rnd_lane1", 64'(out_data[23:12]), 64'(ref_mod(bq.c1, bq.n1)));
          check("rnd_tag", 64'(out_tag), 64'(bq.tag));
        end
        del_n++;
      end
      if (acc_now) begin
        sbq.push_back(cur);
        acc_n++;
      end
      @(posedge clk); #1;
      if (acc_now) in_valid = 1'b0;
    end
    check("rnd_accepted", 64'(acc_n), 10000);
    check("rnd_delivered", 64'(del_n), 64'(acc_n));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
